// File: rtl/deconv_sched_ctrl.sv
// Deconvolution scheduler: walks channels x input columns x kernel columns, 1-cycle export_done->loadip, stalls on wfifo_full/feature valid.
// Optional stall counter output o_stall_cnt when DECONV_SCHED_PERF_CNT_EN is defined.
module deconv_sched_ctrl #(
   parameter int WEIGHT_SIZE  = 5,
   parameter int FEATURE_SIZE = 8,
   parameter int BIT_WIDTH    = 8,
   parameter int CHNL_W       = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_start,
   input  logic [CHNL_W-1:0]                 i_num_chnl,
   input  logic                              i_feat_valid,
   input  logic [BIT_WIDTH*FEATURE_SIZE-1:0] i_feat_col,
   output logic                              o_feat_ready,
   input  logic                              i_wfifo_full,
   input  logic                              i_col_export_done,
   input  logic                              i_dp_valid,
   output logic [BIT_WIDTH*FEATURE_SIZE-1:0] o_feature_map_col,
   output logic                              o_enable_loadip,
   output logic                              o_wfifo_rd_en,
   output logic                              o_wfifo_loop,
   output logic                              o_wfifo_flush,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [$clog2(FEATURE_SIZE)-1:0]   o_col_idx,
   output logic [CHNL_W-1:0]                 o_chnl_idx
`ifdef DECONV_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]                       o_stall_cnt
`endif
);

   localparam int CW = $clog2(FEATURE_SIZE);
   localparam int WW = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH_IP = 4'd1;
   localparam logic [3:0] S_REQ_W    = 4'd2;
   localparam logic [3:0] S_WAIT_W   = 4'd3;
   localparam logic [3:0] S_FIRE     = 4'd4;
   localparam logic [3:0] S_WAIT_DP  = 4'd5;
   localparam logic [3:0] S_ADV      = 4'd6;
   localparam logic [3:0] S_FLUSH    = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   logic [3:0]        state;
   logic [3:0]        nxt;
   logic [CHNL_W-1:0] num_lat;
   logic [WW-1:0]     w_col;
   logic              w_last;
   logic              c_last;
   logic              more_chnl;
   logic              feat_hs;

   assign o_feat_ready = (state == S_FETCH_IP) && i_wfifo_full;
   assign feat_hs      = o_feat_ready && i_feat_valid;
   assign w_last       = (w_col == WW'(WEIGHT_SIZE - 1));
   assign c_last       = (o_col_idx == CW'(FEATURE_SIZE - 1));
   assign more_chnl    = ({1'b0, o_chnl_idx} + (CHNL_W+1)'(1)) < {1'b0, num_lat};

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     if (i_start) nxt = (i_num_chnl == '0) ? S_DONE : S_FETCH_IP;
         S_FETCH_IP: if (feat_hs) nxt = S_REQ_W;
         S_REQ_W:    nxt = S_WAIT_W;
         S_WAIT_W:   if (i_col_export_done) nxt = S_FIRE;
         S_FIRE:     nxt = S_WAIT_DP;
         S_WAIT_DP:  if (i_dp_valid) nxt = S_ADV;
         S_ADV:      nxt = !w_last ? S_REQ_W : (!c_last ? S_FETCH_IP : S_FLUSH);
         S_FLUSH:    nxt = more_chnl ? S_FETCH_IP : S_DONE;
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
   end

   // Pulse outputs are registered from the next state so each is high exactly while its state is.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state             <= S_IDLE;
         num_lat           <= '0;
         w_col             <= '0;
         o_col_idx         <= '0;
         o_chnl_idx        <= '0;
         o_feature_map_col <= '0;
         o_enable_loadip   <= 1'b0;
         o_wfifo_rd_en     <= 1'b0;
         o_wfifo_loop      <= 1'b0;
         o_wfifo_flush     <= 1'b0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
      end else begin
         state           <= nxt;
         o_wfifo_rd_en   <= (nxt == S_REQ_W);
         o_enable_loadip <= (nxt == S_FIRE);
         o_wfifo_loop    <= (state == S_ADV) && (nxt == S_FETCH_IP);
         o_wfifo_flush   <= (nxt == S_FLUSH);
         o_done          <= (nxt == S_DONE);
         o_busy          <= (nxt != S_IDLE);
         case (state)
            S_IDLE: if (i_start) begin
               num_lat    <= i_num_chnl;
               w_col      <= '0;
               o_col_idx  <= '0;
               o_chnl_idx <= '0;
            end
            S_FETCH_IP: if (feat_hs) begin
               o_feature_map_col <= i_feat_col;
               w_col             <= '0;
            end
            S_ADV: begin
               if (!w_last)      w_col     <= w_col + WW'(1);
               else if (!c_last) o_col_idx <= o_col_idx + CW'(1);
            end
            S_FLUSH: begin
               o_col_idx <= '0;
               if (more_chnl) o_chnl_idx <= o_chnl_idx + CHNL_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef DECONV_SCHED_PERF_CNT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_stall_cnt <= '0;
      else if (state == S_IDLE && i_start)
         o_stall_cnt <= '0;
      else if (state == S_WAIT_W || state == S_WAIT_DP)
         o_stall_cnt <= o_stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_deconv_sched_ctrl.sv
// Directed bench for deconv_sched_ctrl with a delayed weight-FIFO/datapath responder and pulse monitor.
module tb_deconv_sched_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [7:0]  i_num_chnl = '0;
   logic        i_feat_valid = 1'b0;
   logic [63:0] i_feat_col = '0;
   logic        o_feat_ready;
   logic        i_wfifo_full = 1'b1;
   logic        i_col_export_done;
   logic        i_dp_valid;
   logic [63:0] o_feature_map_col;
   logic        o_enable_loadip, o_wfifo_rd_en, o_wfifo_loop, o_wfifo_flush;
   logic        o_busy, o_done;
   logic [2:0]  o_col_idx;
   logic [7:0]  o_chnl_idx;
`ifdef DECONV_SCHED_PERF_CNT_EN
   logic [31:0] o_stall_cnt;
`endif

   logic resp_ed = 1'b0, resp_dv = 1'b0, stray_ed = 1'b0, stray_dv = 1'b0;
   assign i_col_export_done = resp_ed | stray_ed;
   assign i_dp_valid        = resp_dv | stray_dv;

   deconv_sched_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_chnl(i_num_chnl),
      .i_feat_valid(i_feat_valid), .i_feat_col(i_feat_col), .o_feat_ready(o_feat_ready),
      .i_wfifo_full(i_wfifo_full), .i_col_export_done(i_col_export_done), .i_dp_valid(i_dp_valid),
      .o_feature_map_col(o_feature_map_col), .o_enable_loadip(o_enable_loadip),
      .o_wfifo_rd_en(o_wfifo_rd_en), .o_wfifo_loop(o_wfifo_loop), .o_wfifo_flush(o_wfifo_flush),
      .o_busy(o_busy), .o_done(o_done), .o_col_idx(o_col_idx), .o_chnl_idx(o_chnl_idx)
`ifdef DECONV_SCHED_PERF_CNT_EN
      , .o_stall_cnt(o_stall_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   int total = 0, bad = 0;
   int w_delay = 2, dp_delay = 2;
   bit feed_en = 0, throttle = 0, hs_pend = 0;
   int ed_cnt = 0, dv_cnt = 0, tick = 0, seq = 0;
   int n_loadip, n_rd, n_loop, n_flush, n_done, n_hs, excl_bad, fmap_bad;
   logic [7:0]  flush_ch [4];
   logic [63:0] last_col = '0;

   function automatic logic [63:0] mk_col(input int s);
      logic [63:0] c;
      for (int i = 0; i < 8; i++) c[i*8 +: 8] = 8'(s + i * 17);
      return c;
   endfunction

   // Weight FIFO / datapath responder and upstream feature source.
   initial begin
      forever begin
         @(posedge i_clk); #1;
         if (i_rst) begin
            ed_cnt = 0; dv_cnt = 0; resp_ed = 0; resp_dv = 0;
         end else begin
            resp_ed = 0;
            if (ed_cnt > 0) begin ed_cnt--; resp_ed = (ed_cnt == 0); end
            if (o_wfifo_rd_en) ed_cnt = w_delay;
            resp_dv = 0;
            if (dv_cnt > 0) begin dv_cnt--; resp_dv = (dv_cnt == 0); end
            if (o_enable_loadip) dv_cnt = dp_delay;
         end
         tick++;
         if (hs_pend) begin seq++; hs_pend = 0; end
         i_feat_col   = mk_col(seq);
         i_feat_valid = feed_en && (!throttle || (tick % 4 == 0));
      end
   end

   initial begin
      forever begin
         @(negedge i_clk);
         if (int'(o_enable_loadip) + int'(o_wfifo_rd_en) + int'(o_wfifo_loop) + int'(o_wfifo_flush) > 1)
            excl_bad++;
         if (o_feat_ready && i_feat_valid) begin n_hs++; last_col = i_feat_col; hs_pend = 1; end
         if (o_enable_loadip) begin
            n_loadip++;
            if (o_feature_map_col !== last_col) fmap_bad++;
         end
         if (o_wfifo_rd_en) n_rd++;
         if (o_wfifo_loop)  n_loop++;
         if (o_wfifo_flush) begin
            if (n_flush < 4) flush_ch[n_flush] = o_chnl_idx;
            n_flush++;
         end
         if (o_done) n_done++;
      end
   end

   task automatic clear_counts();
      n_loadip = 0; n_rd = 0; n_loop = 0; n_flush = 0; n_done = 0; n_hs = 0;
      excl_bad = 0; fmap_bad = 0;
      for (int i = 0; i < 4; i++) flush_ch[i] = '1;
   endtask

   task automatic start_job(input logic [7:0] n);
      i_num_chnl = n; i_start = 1;
      @(posedge i_clk); #1;
      i_start = 0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 0;
      for (int c = 0; c < budget && !ok; c++) begin
         if (o_done) ok = 1;
         else begin @(posedge i_clk); #1; end
      end
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      i_rst = 1;
      repeat (3) @(posedge i_clk);
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", o_done); end
      total++; if (o_feat_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", o_feat_ready); end
      total++; if ({o_enable_loadip, o_wfifo_rd_en, o_wfifo_loop, o_wfifo_flush} !== 4'b0) begin
         bad++; $display("FAIL rst_pulses got=%b want=0000", {o_enable_loadip, o_wfifo_rd_en, o_wfifo_loop, o_wfifo_flush}); end
      total++; if ({o_col_idx, o_chnl_idx} !== 11'd0) begin bad++; $display("FAIL rst_idx got=%0d/%0d want=0/0", o_col_idx, o_chnl_idx); end
      total++; if (o_feature_map_col !== 64'd0) begin bad++; $display("FAIL rst_fmap got=%h want=0", o_feature_map_col); end
      i_rst = 0;
   endtask

   task automatic test_single_chnl();
      bit ok;
      clear_counts(); feed_en = 1; throttle = 0; w_delay = 2; dp_delay = 2;
      start_job(8'd1);
      wait_done(3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL one_done_timeout got=none want=o_done"); end
      total++; if (n_loadip != 40) begin bad++; $display("FAIL one_loadip got=%0d want=40", n_loadip); end
      total++; if (n_rd != 40) begin bad++; $display("FAIL one_rd got=%0d want=40", n_rd); end
      total++; if (n_loop != 7) begin bad++; $display("FAIL one_loop got=%0d want=7", n_loop); end
      total++; if (n_flush != 1) begin bad++; $display("FAIL one_flush got=%0d want=1", n_flush); end
      total++; if (n_done != 1) begin bad++; $display("FAIL one_done got=%0d want=1", n_done); end
      total++; if (n_hs != 8) begin bad++; $display("FAIL one_hs got=%0d want=8", n_hs); end
      total++; if (fmap_bad != 0) begin bad++; $display("FAIL one_fmap got=%0d want=0", fmap_bad); end
      total++; if (excl_bad != 0) begin bad++; $display("FAIL one_excl got=%0d want=0", excl_bad); end
      total++; if (o_busy !== 1'b0 || o_col_idx !== 3'd0) begin bad++; $display("FAIL one_idle got=%b/%0d want=0/0", o_busy, o_col_idx); end
      feed_en = 0;
   endtask

   task automatic test_zero_chnl();
      clear_counts();
      start_job(8'd0);
      total++; if (o_done !== 1'b1 || o_busy !== 1'b1) begin bad++; $display("FAIL zero_done got=%b/%b want=1/1", o_done, o_busy); end
      @(posedge i_clk); #1;
      total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b/%b want=0/0", o_done, o_busy); end
      repeat (2) @(posedge i_clk); #1;
      total++; if (n_rd + n_loadip + n_flush != 0) begin bad++; $display("FAIL zero_pulses got=%0d want=0", n_rd + n_loadip + n_flush); end
   endtask

   task automatic test_multi_throttled();
      bit ok;
      clear_counts(); feed_en = 1; throttle = 1;
      start_job(8'd3);
      wait_done(8000, ok);
      total++; if (!ok) begin bad++; $display("FAIL multi_done_timeout got=none want=o_done"); end
      total++; if (n_loadip != 120) begin bad++; $display("FAIL multi_loadip got=%0d want=120", n_loadip); end
      total++; if (n_flush != 3) begin bad++; $display("FAIL multi_flush got=%0d want=3", n_flush); end
      total++; if (n_loop != 21) begin bad++; $display("FAIL multi_loop got=%0d want=21", n_loop); end
      total++; if (n_hs != 24) begin bad++; $display("FAIL multi_hs got=%0d want=24", n_hs); end
      total++; if (flush_ch[0] !== 8'd0 || flush_ch[1] !== 8'd1 || flush_ch[2] !== 8'd2) begin
         bad++; $display("FAIL multi_chnl_seq got=%0d,%0d,%0d want=0,1,2", flush_ch[0], flush_ch[1], flush_ch[2]); end
      total++; if (fmap_bad + excl_bad != 0) begin bad++; $display("FAIL multi_fmap_excl got=%0d want=0", fmap_bad + excl_bad); end
      feed_en = 0; throttle = 0;
   endtask

   task automatic test_fifo_not_full();
      bit ok;
      int ready_seen = 0;
      clear_counts(); feed_en = 1; i_wfifo_full = 0;
      start_job(8'd1);
      for (int c = 0; c < 10; c++) begin
         stray_ed = (c == 3); stray_dv = (c == 5);
         if (o_feat_ready) ready_seen++;
         @(posedge i_clk); #1;
      end
      stray_ed = 0; stray_dv = 0;
      total++; if (ready_seen != 0) begin bad++; $display("FAIL nf_ready got=%0d want=0", ready_seen); end
      total++; if (n_hs + n_rd + n_loadip != 0) begin bad++; $display("FAIL nf_activity got=%0d want=0", n_hs + n_rd + n_loadip); end
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL nf_busy got=%b want=1", o_busy); end
      i_wfifo_full = 1;
      wait_done(3000, ok);
      total++; if (!ok || n_loadip != 40) begin bad++; $display("FAIL nf_resume got=%0d want=40", n_loadip); end
      feed_en = 0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit found = 0;
      clear_counts(); feed_en = 1;
      start_job(8'd2);
      for (int c = 0; c < 3000 && !found; c++) begin
         if (o_enable_loadip && o_chnl_idx == 8'd1) found = 1;
         @(posedge i_clk); #1;
      end
      total++; if (!found) begin bad++; $display("FAIL mid_reach got=none want=chnl1 loadip"); end
      i_rst = 1;
      @(posedge i_clk); #1;
      total++; if ({o_busy, o_done, o_feat_ready, o_enable_loadip, o_wfifo_rd_en, o_wfifo_loop, o_wfifo_flush} !== 7'd0) begin
         bad++; $display("FAIL mid_outs got=%b want=0", {o_busy, o_done, o_feat_ready, o_enable_loadip, o_wfifo_rd_en, o_wfifo_loop, o_wfifo_flush}); end
      total++; if (o_chnl_idx !== 8'd0 || o_col_idx !== 3'd0 || o_feature_map_col !== 64'd0) begin
         bad++; $display("FAIL mid_state got=%0d/%0d/%h want=0/0/0", o_chnl_idx, o_col_idx, o_feature_map_col); end
      @(posedge i_clk); #1;
      i_rst = 0;
      clear_counts();
      start_job(8'd1);
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_restart got=%b want=1", o_busy); end
      wait_done(3000, ok);
      total++; if (!ok || n_loadip != 40 || n_flush != 1) begin bad++; $display("FAIL mid_clean got=%0d/%0d want=40/1", n_loadip, n_flush); end
      feed_en = 0;
   endtask

`ifdef DECONV_SCHED_PERF_CNT_EN
   task automatic test_perf();
      logic [31:0] at_done;
      bit found = 0;
      clear_counts(); feed_en = 1; dp_delay = 5;
      start_job(8'd1);
      total++; if (o_stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_clear got=%0d want=0", o_stall_cnt); end
      at_done = '0;
      for (int c = 0; c < 5000 && !found; c++) begin
         if (o_done) begin found = 1; at_done = o_stall_cnt; end
         else begin @(posedge i_clk); #1; end
      end
      total++; if (!found || at_done < 32'd200) begin bad++; $display("FAIL perf_stall got=%0d want>=200", at_done); end
      repeat (4) @(posedge i_clk); #1;
      total++; if (o_stall_cnt !== at_done) begin bad++; $display("FAIL perf_hold got=%0d want=%0d", o_stall_cnt, at_done); end
      feed_en = 0; dp_delay = 2;
   endtask
`endif

   initial begin
      clear_counts();
      #1;
      test_reset();
      test_single_chnl();
      test_zero_chnl();
      test_multi_throttled();
      test_fifo_not_full();
      test_reset_mid();
`ifdef DECONV_SCHED_PERF_CNT_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
